mem_arbiter: RTL

- Shares the single-ported 16-bit unified memory between the fetch-stage (IF) and memory-stage (DM) requesters of the pipelined processor.
- Sequences each multi-cycle access and returns read data with a one-cycle done pulse.
- Drives the per-requester stall lines that freeze the pipeline while an access is pending.
- DM has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter_access_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing helpers for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Counter width able to hold MEM_LAT (the timer itself only needs MEM_LAT-1).
  function automatic int unsigned timer_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

  function automatic int unsigned streak_width(input int unsigned smax);
    return (smax < 1) ? 1 : $clog2(smax + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              dm_req;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_done, if_stall,
    output dm_rdata, dm_done, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_wr, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_done, if_stall,
    input  dm_rdata, dm_done, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_access_timer.sv
// Loadable down-counter timing one memory access; zero marks the final access cycle.
module access_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-ported memory between fetch (IF) and data (DM) requesters.
// DM has priority; after STARVE_MAX consecutive DM grants a waiting fetch is forced through.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned MEM_LAT    = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned TW = timer_width(MEM_LAT);
  localparam int unsigned SW = streak_width(STARVE_MAX);
  localparam logic [TW-1:0] TIMER_INIT = TW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  arb_state_t    state;
  logic [SW-1:0] dm_streak;
  logic          grant_dm;
  logic          grant_if;
  logic          in_access;
  logic          timer_load;
  logic          timer_dec;
  logic          timer_zero;

  always_comb begin
    grant_dm   = bus.dm_req && !(bus.if_req && (dm_streak == STREAK_MAX));
    grant_if   = !grant_dm && bus.if_req;
    in_access  = (state == ACC_I) || (state == ACC_D);
    timer_load = (state == IDLE) && (grant_dm || grant_if);
    timer_dec  = in_access && !timer_zero;
  end

  access_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (timer_load),
    .load_val (TIMER_INIT),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dm_streak     <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.dm_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state         <= ACC_D;
            bus.mem_en    <= 1'b1;
            bus.mem_wr    <= bus.dm_wr;
            bus.mem_addr  <= bus.dm_addr[ADDR_W-1:0];
            bus.mem_wdata <= bus.dm_wdata[DATA_W-1:0];
            // Streak counts every DM grant, including ones with no fetch waiting.
            if (dm_streak != STREAK_MAX) begin
              dm_streak <= dm_streak + SW'(1);
            end
          end else if (grant_if) begin
            state        <= ACC_I;
            bus.mem_en   <= 1'b1;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= bus.if_addr[ADDR_W-1:0];
            dm_streak    <= '0;
          end
        end
        ACC_I, ACC_D: begin
          if (timer_zero) begin
            if (state == ACC_I) begin
              bus.if_rdata <= bus.mem_rdata[DATA_W-1:0];
            end else if (!bus.mem_wr) begin
              bus.dm_rdata <= bus.mem_rdata[DATA_W-1:0];
            end
            bus.if_done <= (state == ACC_I);
            bus.dm_done <= (state == ACC_D);
            bus.mem_en  <= 1'b0;
            bus.mem_wr  <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          bus.if_done <= 1'b0;
          bus.dm_done <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_stall = bus.if_req && !bus.if_done;
  assign bus.dm_stall = bus.dm_req && !bus.dm_done;

endmodule
